ht_decode: RTL and testbench

Serial Huffman decoder: the receive-side counterpart of the Huffman encoder, turning the encoder's MSB-first `out_code` bitstream back into character indices. A code table is loaded first: one (length, code) entry for each of the 8 characters A, B, C, E, I, L, O, V (indices 0..7). Serial bits are then accepted, shifted into an accumulator, and matched against the table. The block emits one character index per matched codeword and stops after `NUM_CHAR` characters.

---
 rtl/ht_decode.sv | 130 +++++++++++++
 tb/tb_ht_decode.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ht_decode.sv
// rtl/ht_decode.sv - serial Huffman decoder with a loadable 8-entry code table
// Optional HT_DECODE_ERR_EN: flag and abort on an undecodable 7-bit sequence.
module ht_decode #(
  parameter int NUM_CHAR = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tbl_valid,
  input  logic [2:0] tbl_len,
  input  logic [6:0] tbl_code,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic       out_valid,
  output logic [2:0] out_char,
  output logic       out_last,
  output logic       out_err
);
  typedef enum logic [1:0] {IDLE, LOAD, DECODE} state_t;
  localparam logic [3:0] LAST_CNT = 4'(NUM_CHAR - 1);

  state_t     state;
  logic [2:0] len_rf  [8];
  logic [6:0] code_rf [8];
  logic [6:0] acc;
  logic [2:0] k;
  logic [3:0] ccnt;
  logic [2:0] idx;
  logic [6:0] nacc;
  logic [6:0] mask;
  logic [2:0] nk;
  logic [2:0] hit_char;
  logic       hit;

`ifdef HT_DECODE_ERR_EN
  logic err_q;
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  assign nacc = {acc[5:0], bit_in};
  assign nk   = k + 3'd1;
  assign mask = ~(7'h7f << nk);

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_char = 3'd0;
    for (int c = 7; c >= 0; c--) begin
      if (len_rf[c] == nk && ((code_rf[c] ^ nacc) & mask) == 7'd0) begin
        hit      = 1'b1;
        hit_char = 3'(c);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= 7'd0;
      k         <= 3'd0;
      ccnt      <= 4'd0;
      idx       <= 3'd0;
      out_valid <= 1'b0;
      out_char  <= 3'd0;
      out_last  <= 1'b0;
`ifdef HT_DECODE_ERR_EN
      err_q     <= 1'b0;
`endif
      for (int i = 0; i < 8; i++) begin
        len_rf[i]  <= 3'd0;
        code_rf[i] <= 7'd0;
      end
    end else begin
      out_valid <= 1'b0;
      out_char  <= 3'd0;
      out_last  <= 1'b0;
`ifdef HT_DECODE_ERR_EN
      err_q     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          acc  <= 7'd0;
          k    <= 3'd0;
          ccnt <= 4'd0;
          if (tbl_valid) begin
            len_rf[0]  <= tbl_len;
            code_rf[0] <= tbl_code;
            idx        <= 3'd1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (tbl_valid) begin
            len_rf[idx]  <= tbl_len;
            code_rf[idx] <= tbl_code;
            idx          <= idx + 3'd1;
            if (idx == 3'd7) state <= DECODE;
          end
        end
        DECODE: begin
          if (bit_valid) begin
            if (hit) begin
              out_valid <= 1'b1;
              out_char  <= hit_char;
              acc       <= 7'd0;
              k         <= 3'd0;
              ccnt      <= ccnt + 4'd1;
              if (ccnt == LAST_CNT) begin
                out_last <= 1'b1;
                state    <= IDLE;
              end
            end else if (nk != 3'd7) begin
              acc <= nacc;
              k   <= nk;
            end else begin
              acc <= 7'd0;
              k   <= 3'd0;
`ifdef HT_DECODE_ERR_EN
              err_q <= 1'b1;
              state <= IDLE;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ht_decode.sv
// tb/tb_ht_decode.sv - self-checking bench for ht_decode
// Compares every cycle against a queue-based decode model, plus literal sequence checks.
module tb_ht_decode;
  localparam int NC = 5;
`ifdef HT_DECODE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tbl_valid;
  logic [2:0] tbl_len;
  logic [6:0] tbl_code;
  logic       bit_valid;
  logic       bit_in;
  logic       out_valid;
  logic [2:0] out_char;
  logic       out_last;
  logic       out_err;

  int total = 0;
  int bad   = 0;

  int ilove_len [8] = '{2, 2, 3, 3, 4, 4, 4, 4};
  int ilove_code[8] = '{0, 1, 4, 5, 12, 13, 14, 15};
  int nov_len   [8] = '{2, 2, 3, 3, 4, 4, 4, 0};
  int seq_ilove [5] = '{4, 5, 6, 7, 3};
  int seq_iclab [5] = '{4, 2, 5, 0, 1};
  int seq_iiiii [5] = '{4, 4, 4, 4, 4};

  always #5 clk = ~clk;

  ht_decode #(.NUM_CHAR(NC)) dut (
    .clk(clk), .rst(rst),
    .tbl_valid(tbl_valid), .tbl_len(tbl_len), .tbl_code(tbl_code),
    .bit_valid(bit_valid), .bit_in(bit_in),
    .out_valid(out_valid), .out_char(out_char), .out_last(out_last), .out_err(out_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: table entries, the pending codeword as a bit queue, and a char count.
  int   m_mode;
  int   m_idx;
  int   m_cnt;
  int   m_len [8];
  int   m_code[8];
  bit   m_q[$];
  logic e_valid, e_last, e_err;
  logic [2:0] e_char;

  always @(posedge clk or posedge rst) begin
    int v, n, found;
    e_valid = 1'b0; e_char = 3'd0; e_last = 1'b0; e_err = 1'b0;
    if (rst) begin
      m_mode = 0; m_idx = 0; m_cnt = 0; m_q.delete();
      for (int i = 0; i < 8; i++) begin m_len[i] = 0; m_code[i] = 0; end
    end else if (m_mode != 2) begin
      if (m_mode == 0) begin m_q.delete(); m_cnt = 0; m_idx = 0; end
      if (tbl_valid) begin
        m_len[m_idx] = int'(tbl_len);
        m_code[m_idx] = int'(tbl_code);
        m_idx++;
        m_mode = (m_idx == 8) ? 2 : 1;
      end
    end else if (bit_valid) begin
      m_q.push_back(bit_in);
      n = m_q.size();
      v = 0;
      foreach (m_q[i]) v = v * 2 + int'(m_q[i]);
      found = -1;
      for (int c = 0; c < 8 && found < 0; c++)
        if (m_len[c] == n && (m_code[c] % (1 << n)) == v) found = c;
      if (found >= 0) begin
        e_valid = 1'b1; e_char = 3'(found);
        m_q.delete();
        m_cnt++;
        if (m_cnt == NC) begin e_last = 1'b1; m_mode = 0; end
      end else if (n == 7) begin
        m_q.delete();
        if (ERR_EN) begin e_err = 1'b1; m_mode = 0; end
      end
    end
  end

  int ncyc = 0;
  int first_bit = -1;
  bit arm = 1'b0;
  int got_char[$];
  int got_cyc[$];
  int n_last = 0;
  int last_char = -1;
  int n_err = 0;

  always @(negedge clk) begin
    ncyc++;
    chk("out_valid", out_valid, e_valid);
    chk("out_char", out_char, e_char);
    chk("out_last", out_last, e_last);
    chk("out_err", out_err, e_err);
    if (arm && bit_valid && first_bit < 0) first_bit = ncyc;
    if (out_valid === 1'b1) begin got_char.push_back(int'(out_char)); got_cyc.push_back(ncyc); end
    if (out_last === 1'b1) begin n_last++; last_char = int'(out_char); end
    if (out_err === 1'b1) n_err++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    got_char.delete(); got_cyc.delete();
    n_last = 0; last_char = -1; n_err = 0; first_bit = -1;
  endtask

  task automatic load(input int lens[8], input int codes[8], input int maxgap);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        repeat ($urandom_range(0, maxgap)) begin
          tbl_valid = 1'b0;
          tbl_len   = 3'($urandom_range(0, 7));
          tbl_code  = 7'($urandom_range(0, 127));
          bit_valid = 1'($urandom_range(0, 1));
          bit_in    = 1'($urandom_range(0, 1));
          tick();
        end
      end
      tbl_valid = 1'b1;
      tbl_len   = 3'(lens[i]);
      tbl_code  = 7'(codes[i]);
      bit_valid = 1'($urandom_range(0, 1));
      tick();
    end
    tbl_valid = 1'b0;
    bit_valid = 1'b0;
  endtask

  task automatic send(input string s, input int maxgap);
    for (int i = 0; i < s.len(); i++) begin
      repeat ($urandom_range(0, maxgap)) begin
        bit_valid = 1'b0;
        bit_in    = 1'($urandom_range(0, 1));
        tbl_valid = 1'($urandom_range(0, 1));
        tbl_len   = 3'($urandom_range(0, 7));
        tick();
      end
      tbl_valid = 1'b0;
      bit_valid = 1'b1;
      bit_in    = (s[i] == "1");
      tick();
    end
    bit_valid = 1'b0;
  endtask

  task automatic chk_seq(input string name, input int exp[5]);
    chk({name, "_count"}, got_char.size(), 5);
    for (int i = 0; i < 5 && i < got_char.size(); i++)
      chk({name, "_char"}, got_char[i], exp[i]);
    chk({name, "_last_count"}, n_last, 1);
    chk({name, "_last_char"}, last_char, exp[4]);
  endtask

  initial begin
    rst = 1'b1; tbl_valid = 1'b0; tbl_len = 3'd0; tbl_code = 7'd0;
    bit_valid = 1'b0; bit_in = 1'b0;
    tick();
    repeat (8) begin
      tbl_valid = 1'($urandom_range(0, 1));
      tbl_len   = 3'($urandom_range(0, 7));
      tbl_code  = 7'($urandom_range(0, 127));
      bit_valid = 1'($urandom_range(0, 1));
      bit_in    = 1'($urandom_range(0, 1));
      tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_err", out_err, 0);
    end
    tbl_valid = 1'b0; bit_valid = 1'b0; rst = 1'b0;
    tick();

    // ILOVE, contiguous bits
    load(ilove_len, ilove_code, 0);
    clear_log(); arm = 1'b1;
    send("1100110111101111101", 0);
    arm = 1'b0;
    repeat (3) tick();
    chk_seq("ilove", seq_ilove);
    if (got_cyc.size() == 5) begin
      chk("ilove_lat0", got_cyc[0] - first_bit, 4);
      chk("ilove_lat1", got_cyc[1] - got_cyc[0], 4);
      chk("ilove_lat2", got_cyc[2] - got_cyc[1], 4);
      chk("ilove_lat3", got_cyc[3] - got_cyc[2], 4);
      chk("ilove_lat4", got_cyc[4] - got_cyc[3], 3);
    end

    // ICLAB with table and bit gaps; load starts right after out_last
    clear_log();
    load(ilove_len, ilove_code, 2);
    send("110010011010001", 3);
    repeat (3) tick();
    chk_seq("iclab", seq_iclab);

    // undecodable 1111111 with V disabled, then five I codes
    clear_log();
    load(nov_len, ilove_code, 1);
    send("111111111001100110011001100", 0);
    repeat (3) tick();
`ifdef HT_DECODE_ERR_EN
    chk("err_pulses", n_err, 1);
    chk("err_no_chars", got_char.size(), 0);
`else
    chk("err_pulses", n_err, 0);
    chk_seq("err_cont", seq_iiiii);
`endif

    // reset while the second char is on the outputs
    clear_log();
    load(ilove_len, ilove_code, 0);
    for (int i = 0; i < 19 && (got_char.size() + int'(out_valid === 1'b1)) < 2; i++) begin
      bit_valid = 1'b1;
      bit_in    = (i % 4 < 2) || (i == 7);
      tick();
    end
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1; bit_valid = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_char", out_char, 0);
    chk("async_rst_last", out_last, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    clear_log();
    load(ilove_len, ilove_code, 2);
    send("1100110111101111101", 1);
    repeat (3) tick();
    chk_seq("post_rst", seq_ilove);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
